// File: rtl/mem_if_pkg.sv
// Shared types for the cache-to-memory block port: FSM states, owner and operation codes.
package mem_if_pkg;

    localparam int unsigned BLOCK_ADDR_W = 6;
    localparam int unsigned BLOCK_W      = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the side that did not own last.
module rr_arb2
    import mem_if_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       grant_valid,
    output owner_t     grant_owner
);

    always_comb begin
        grant_valid = |req;
        grant_owner = OWN_I;
        case (req)
            2'b01:   grant_owner = OWN_I;
            2'b10:   grant_owner = OWN_D;
            2'b11: begin
                if (last_owner == OWN_I) begin
                    grant_owner = OWN_D;
                end else begin
                    grant_owner = OWN_I;
                end
            end
            default: grant_owner = OWN_I;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single block-wide memory port between icache refill and dcache refill/write-back,
// one whole-block transaction at a time, with round-robin selection and busywait completion.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W     = BLOCK_ADDR_W,
    parameter int unsigned DATA_W     = BLOCK_W,
    parameter bit          FIRST_PRIO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    localparam owner_t RESET_LAST = FIRST_PRIO ? OWN_I : OWN_D;

    state_t state, state_next;
    owner_t owner, last_owner;
    op_t    op;

    logic   req_i, req_d;
    logic   grant_valid;
    owner_t grant_owner;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    rr_arb2 u_arb (
        .req         ({req_d, req_i}),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign i_busywait = req_i & ~((state == RESP) & (owner == OWN_I));
    assign d_busywait = req_d & ~((state == RESP) & (owner == OWN_D));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid)    state_next = ISSUE;
            ISSUE:   if (mem_busywait)   state_next = WAIT;
            WAIT:    if (!mem_busywait)  state_next = RESP;
            RESP:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWN_I;
            last_owner    <= RESET_LAST;
            op            <= OP_READ;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // Everything the memory sees is captured here so later input changes cannot leak in.
                    if (grant_valid) begin
                        owner <= grant_owner;
                        if (grant_owner == OWN_I) begin
                            op          <= OP_READ;
                            mem_read    <= 1'b1;
                            mem_address <= i_address;
                        end else begin
                            mem_address <= d_address;
                            if (d_write) begin
                                op            <= OP_WRITE;
                                mem_write     <= 1'b1;
                                mem_writedata <= d_writedata;
                            end else begin
                                op       <= OP_READ;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (op == OP_READ) begin
                            if (owner == OWN_I) begin
                                i_readdata <= mem_readdata;
                            end else begin
                                d_readdata <= mem_readdata;
                            end
                        end
                    end
                end
                RESP: last_owner <= owner;
                default: ;
            endcase
        end
    end

endmodule
